uart_tx_ctrl: RTL and testbench

Transmit-side controller for the board-to-host UART link; the counterpart of the receive controller on the same link. Serialises three frame types, each starting with a control byte: connect acknowledge, score sync and map sync. Frames use 8N1 framing, LSB first, and the line idles high. Contains its own bit-timing serialiser, so it drives the TX pin directly.

---
 rtl/uart_tx_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// Board-to-host UART transmit controller: queues ACK / score / map frame requests
// and serialises them as 8N1 bytes, control byte first, LSB-first bits, idle-high line.
module uart_tx_ctrl #(
  parameter int unsigned CLK_PER_BIT     = 868,
  parameter logic [7:0]  CTRL_ACK        = 8'hFF,
  parameter logic [7:0]  CTRL_SYNC_SCORE = 8'h01,
  parameter logic [7:0]  CTRL_SYNC_MAP   = 8'h02
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_send_ack,
  input  logic         i_send_score,
  input  logic         i_send_map,
  input  logic [15:0]  i_score,
  input  logic [127:0] i_dot,
  output logic         o_tx,
  output logic         o_busy,
  output logic         o_done
);

  localparam int unsigned CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  baud;
  logic [2:0]     bit_idx;
  logic [4:0]     byte_idx;
  logic [4:0]     len;
  logic [135:0]   frame;
  logic           pend_ack, pend_score, pend_map;
  logic           req_ack, req_score, req_map;
  logic           take_ack, take_score, take_map;
  logic           bit_end;
  logic           line;
  logic [7:0]     cur_byte;

  assign req_ack   = pend_ack   | i_send_ack;
  assign req_score = pend_score | i_send_score;
  assign req_map   = pend_map   | i_send_map;
  assign bit_end   = (baud == CW'(CLK_PER_BIT - 1));
  // The byte on the line always sits in the top of the shadow register.
  assign cur_byte  = frame[135:128];

  always_comb begin
    state_next = state;
    line       = 1'b1;
    take_ack   = 1'b0;
    take_score = 1'b0;
    take_map   = 1'b0;
    case (state)
      IDLE: begin
        if (req_ack) begin
          take_ack   = 1'b1;
          state_next = START;
        end else if (req_score) begin
          take_score = 1'b1;
          state_next = START;
        end else if (req_map) begin
          take_map   = 1'b1;
          state_next = START;
        end
      end
      START: begin
        line = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        line = cur_byte[bit_idx];
        if (bit_end && bit_idx == 3'd7) state_next = STOP;
      end
      STOP: begin
        if (bit_end) state_next = (byte_idx < len - 5'd1) ? START : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      len        <= '0;
      frame      <= '0;
      pend_ack   <= 1'b0;
      pend_score <= 1'b0;
      pend_map   <= 1'b0;
      o_tx       <= 1'b1;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state  <= state_next;
      // Outputs lag the state by one cycle, so o_done lands on the first idle-high cycle.
      o_tx   <= line;
      o_busy <= (state != IDLE);
      o_done <= o_busy && (state == IDLE);

      if (state == IDLE || bit_end) baud <= '0;
      else                          baud <= baud + 1'b1;

      if (state == DATA && bit_end) bit_idx <= bit_idx + 3'd1;

      pend_ack   <= take_ack   ? 1'b0 : req_ack;
      pend_score <= take_score ? 1'b0 : req_score;
      pend_map   <= take_map   ? 1'b0 : req_map;

      if (take_ack) begin
        frame    <= {CTRL_ACK, 128'h0};
        len      <= 5'd1;
        byte_idx <= '0;
      end else if (take_score) begin
        frame    <= {CTRL_SYNC_SCORE, i_score, 112'h0};
        len      <= 5'd3;
        byte_idx <= '0;
      end else if (take_map) begin
        frame    <= {CTRL_SYNC_MAP, i_dot};
        len      <= 5'd17;
        byte_idx <= '0;
      end else if (state == STOP && bit_end && state_next == START) begin
        byte_idx <= byte_idx + 5'd1;
        frame    <= {frame[127:0], 8'h00};
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: timeline-level reference model compared
// every cycle, plus directed frame decodes with literal expected bytes.
module tb_uart_tx_ctrl;

  localparam int unsigned C = 4;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_send_ack = 1'b0;
  logic         i_send_score = 1'b0;
  logic         i_send_map = 1'b0;
  logic [15:0]  i_score = '0;
  logic [127:0] i_dot = '0;
  logic         o_tx, o_busy, o_done;

  uart_tx_ctrl #(.CLK_PER_BIT(C)) dut (
    .clk(clk), .i_rst(i_rst), .i_send_ack(i_send_ack), .i_send_score(i_send_score),
    .i_send_map(i_send_map), .i_score(i_score), .i_dot(i_dot),
    .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a frame accepted at edge a drives the line during the cycles
  // after edges a+1..a+L (L = bytes*10*C); o_done follows at edge a+L+1, and the
  // earliest next acceptance is that same edge.
  longint     n = 0;
  bit         mvalid = 0;
  bit         pa = 0, ps = 0, pm = 0;
  bit         active = 0;
  longint     a = 0, flen = 0, can_acc = 0;
  logic [7:0] fb[$];
  logic       exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;
  longint     j, pos;
  logic [7:0] bt;
  bit         ea, es, em;

  always @(posedge clk) begin
    n++;
    if (i_rst) begin
      mvalid = 1; pa = 0; ps = 0; pm = 0; active = 0;
      exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
      can_acc = n + 1;
    end else if (mvalid) begin
      exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
      if (active) begin
        if (n >= a + 1 && n <= a + flen) begin
          j   = (n - a - 1) / C;
          bt  = fb[j / 10];
          pos = j % 10;
          exp_tx   = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : bt[pos - 1];
          exp_busy = 1'b1;
        end else if (n == a + flen + 1) begin
          exp_done = 1'b1;
        end
      end
      ea = pa | i_send_ack; es = ps | i_send_score; em = pm | i_send_map;
      if (n >= can_acc && (ea || es || em)) begin
        fb.delete();
        active = 1; a = n;
        if (ea) begin
          fb.push_back(8'hFF);
          pa = 0; ps = es; pm = em;
        end else if (es) begin
          fb.push_back(8'h01); fb.push_back(i_score[15:8]); fb.push_back(i_score[7:0]);
          pa = 0; ps = 0; pm = em;
        end else begin
          fb.push_back(8'h02);
          for (int k = 15; k >= 0; k--) fb.push_back(i_dot[k*8 +: 8]);
          pa = 0; ps = 0; pm = 0;
        end
        flen    = fb.size() * 10 * C;
        can_acc = n + flen + 1;
      end else begin
        pa = ea; ps = es; pm = em;
      end
    end
  end

  // Per-cycle comparison plus a recorder of busy line samples for literal decodes.
  logic        line_q[$];
  int unsigned done_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (mvalid) begin
      chk("cycle_tx",   o_tx,   exp_tx);
      chk("cycle_busy", o_busy, exp_busy);
      chk("cycle_done", o_done, exp_done);
    end
    if (o_busy) line_q.push_back(o_tx);
    if (o_done) done_cnt++;
  end

  function automatic bit model_quiet();
    return (!active || n > a + flen + 1) && !pa && !ps && !pm;
  endfunction

  task automatic clear_rec();
    line_q.delete();
    done_cnt = 0;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (model_quiet()) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout actual=busy required=idle within %0d cycles", name, budget);
  endtask

  task automatic pulse(input bit pa_i, input bit ps_i, input bit pm_i);
    @(negedge clk);
    i_send_ack = pa_i; i_send_score = ps_i; i_send_map = pm_i;
    @(negedge clk);
    i_send_ack = 1'b0; i_send_score = 1'b0; i_send_map = 1'b0;
  endtask

  task automatic check_line(input string name, input logic [7:0] exp_b[$], input int unsigned exp_done);
    int unsigned base;
    logic [9:0]  got;
    chk($sformatf("%s_busy_cycles", name), line_q.size(), exp_b.size() * 10 * C);
    chk($sformatf("%s_done_pulses", name), done_cnt, exp_done);
    for (int b = 0; b < exp_b.size(); b++) begin
      base = b * 10 * C;
      if (line_q.size() >= base + 10 * C) begin
        for (int i = 0; i < 10; i++) got[i] = line_q[base + i * C + C / 2];
        chk($sformatf("%s_byte%0d", name, b), {22'h0, got}, {22'h0, 1'b1, exp_b[b], 1'b0});
      end
    end
  endtask

  function automatic void push_map(inout logic [7:0] q[$], input logic [127:0] d);
    q.push_back(8'h02);
    for (int k = 15; k >= 0; k--) q.push_back(d[k*8 +: 8]);
  endfunction

  logic [7:0]   eb[$];
  logic [15:0]  sc;
  logic [127:0] dt;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tx",   o_tx,   1'b1);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_done", o_done, 1'b0);
    i_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single ACK frame
    clear_rec();
    pulse(1, 0, 0);
    wait_quiet("ack", 200);
    eb.delete(); eb.push_back(8'hFF);
    check_line("ack", eb, 1);

    // Score frame; input changes after capture must not matter
    clear_rec();
    i_score = 16'hA55A;
    pulse(0, 1, 0);
    i_score = 16'h0000;
    wait_quiet("score", 400);
    eb.delete(); eb.push_back(8'h01); eb.push_back(8'hA5); eb.push_back(8'h5A);
    check_line("score", eb, 1);

    // Map frame
    clear_rec();
    i_dot = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    pulse(0, 0, 1);
    wait_quiet("map", 1000);
    eb.delete();
    eb.push_back(8'h02);
    eb.push_back(8'h00); eb.push_back(8'h11); eb.push_back(8'h22); eb.push_back(8'h33);
    eb.push_back(8'h44); eb.push_back(8'h55); eb.push_back(8'h66); eb.push_back(8'h77);
    eb.push_back(8'h88); eb.push_back(8'h99); eb.push_back(8'hAA); eb.push_back(8'hBB);
    eb.push_back(8'hCC); eb.push_back(8'hDD); eb.push_back(8'hEE); eb.push_back(8'hFF);
    check_line("map", eb, 1);

    // All three at once: ACK, SCORE, MAP back to back
    clear_rec();
    sc = 16'($urandom);
    dt = {$urandom, $urandom, $urandom, $urandom};
    i_score = sc; i_dot = dt;
    pulse(1, 1, 1);
    wait_quiet("all3", 2000);
    eb.delete();
    eb.push_back(8'hFF);
    eb.push_back(8'h01); eb.push_back(sc[15:8]); eb.push_back(sc[7:0]);
    push_map(eb, dt);
    check_line("all3", eb, 3);

    // Map requested mid-ACK, then two duplicate pulses during the map frame
    clear_rec();
    pulse(1, 0, 0);
    repeat (10) @(negedge clk);
    pulse(0, 0, 1);
    repeat (60) @(negedge clk);
    pulse(0, 0, 1);
    repeat (100) @(negedge clk);
    pulse(0, 0, 1);
    wait_quiet("merge", 3000);
    eb.delete();
    eb.push_back(8'hFF);
    push_map(eb, dt);
    push_map(eb, dt);
    check_line("merge", eb, 3);

    // Reset during the second score byte with an ACK pending
    i_score = 16'h1234;
    pulse(0, 1, 0);
    repeat (10) @(negedge clk);
    pulse(1, 0, 0);
    repeat (40) @(negedge clk);
    chk("pre_reset_busy", o_busy, 1'b1);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    chk("rst_mid_tx",   o_tx,   1'b1);
    chk("rst_mid_busy", o_busy, 1'b0);
    chk("rst_mid_done", o_done, 1'b0);
    clear_rec();
    repeat (200) @(negedge clk);
    chk("rst_mid_no_frames", line_q.size(), 0);
    chk("rst_mid_no_done",   done_cnt,      0);

    // Randomised traffic, occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      i_send_ack   = ($urandom_range(0, 199) == 0);
      i_send_score = ($urandom_range(0, 149) == 0);
      i_send_map   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) i_score = 16'($urandom);
      if ($urandom_range(0, 19) == 0) i_dot = {$urandom, $urandom, $urandom, $urandom};
      i_rst = ($urandom_range(0, 1499) == 0);
    end
    @(negedge clk);
    i_send_ack = 1'b0; i_send_score = 1'b0; i_send_map = 1'b0; i_rst = 1'b0;
    wait_quiet("random_drain", 3000);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
